// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI transaction arbiter: FSM state encoding,
// default parameter values and width helpers.
package spi_arb_pkg;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_DATA_W        = 8;
    localparam int DEF_START_TIMEOUT = 64;
    localparam int DEF_XFER_TIMEOUT  = 1024;
    localparam int DEF_GAP_CYCLES    = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_XFER    = 3'd2,
        S_CAPTURE = 3'd3,
        S_ERR     = 3'd4,
        S_GAP     = 3'd5
    } arb_state_t;

    // Bits needed to index 'value' distinct items; never less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: the first requester after rr_ptr
// (wrapping modulo NUM_REQ) wins, so the last winner has lowest priority.
module rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]        gnt_oh,
    output logic [clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                      gnt_any
);

    localparam int IDX_W = clog2(NUM_REQ);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        gnt_oh   = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(rr_ptr) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!gnt_any && req_valid[cand_idx]) begin
                gnt_any          = 1'b1;
                gnt_idx          = cand_idx;
                gnt_oh[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin sharing of one SPI Master byte engine among NUM_REQ requesters;
// each grant runs one full byte transfer and returns the received byte or a timeout error.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int XFER_TIMEOUT  = DEF_XFER_TIMEOUT,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       reqValid,
    input  logic [NUM_REQ*DATA_W-1:0] reqData,
    output logic [NUM_REQ-1:0]       reqReady,
    output logic [NUM_REQ-1:0]       rspValid,
    output logic [DATA_W-1:0]        rspData,
    output logic                     rspError,
    output logic                     busy,
    output logic                     sendStart,
    output logic [DATA_W-1:0]        sendData,
    input  logic [DATA_W-1:0]        recvData,
    input  logic                     SPI_CS,
    output arb_state_t               dbg_state
);

    // Handshake: a request is held on reqValid[i] until the single-cycle reqReady[i]
    // pulse (data latched that cycle); the answer is a single-cycle rspValid[i] pulse
    // with rspData/rspError valid in the same cycle. There is no backpressure on responses.

    localparam int IDX_W   = clog2(NUM_REQ);
    localparam int TMR_MAX = max3(START_TIMEOUT, XFER_TIMEOUT, GAP_CYCLES);
    localparam int TMR_W   = clog2(TMR_MAX + 1);

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  gnt_idx_q;
    logic [TMR_W-1:0]  timer;
    logic              cs_q;
    logic              send_start_q;
    logic [DATA_W-1:0] send_data_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [NUM_REQ-1:0] gnt_dec;
    logic               cs_fall, cs_rise;
    logic               start_expired, xfer_expired, gap_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_valid (reqValid),
        .rr_ptr    (rr_ptr),
        .gnt_oh    (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_any   (arb_any)
    );

    // SPI_CS shares clk with the Master, so one register is enough for edge detection.
    assign cs_fall = cs_q & ~SPI_CS;
    assign cs_rise = ~cs_q & SPI_CS;

    assign start_expired = (timer == TMR_W'(START_TIMEOUT - 1));
    assign xfer_expired  = (timer == TMR_W'(XFER_TIMEOUT - 1));
    assign gap_done      = (timer == TMR_W'(GAP_CYCLES - 1));
    assign gnt_dec       = NUM_REQ'(1) << gnt_idx_q;

    always_comb begin
        state_nxt = state;
        reqReady  = '0;
        rspValid  = '0;
        rspData   = '0;
        rspError  = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb_any && !rst) begin
                    reqReady  = arb_gnt;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Only a true falling edge counts; a CS already low never advances.
                if (cs_fall) begin
                    state_nxt = S_XFER;
                end else if (start_expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_XFER: begin
                if (cs_rise) begin
                    state_nxt = S_CAPTURE;
                end else if (xfer_expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_CAPTURE: begin
                rspValid  = gnt_dec;
                rspData   = recvData;
                state_nxt = S_GAP;
            end
            S_ERR: begin
                rspValid  = gnt_dec;
                rspError  = 1'b1;
                state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            rr_ptr       <= IDX_W'(NUM_REQ - 1);
            gnt_idx_q    <= '0;
            timer        <= '0;
            cs_q         <= 1'b1;
            send_start_q <= 1'b0;
            send_data_q  <= '0;
        end else begin
            state <= state_nxt;
            cs_q  <= SPI_CS;

            // Every state starts its own count from zero; the count saturates.
            if (state_nxt != state) begin
                timer <= '0;
            end else if (timer != {TMR_W{1'b1}}) begin
                timer <= timer + 1'b1;
            end

            if (state == S_IDLE && arb_any) begin
                send_data_q  <= reqData[int'(arb_idx)*DATA_W +: DATA_W];
                gnt_idx_q    <= arb_idx;
                rr_ptr       <= arb_idx;
                send_start_q <= 1'b1;
            end else if (state == S_LAUNCH && state_nxt != S_LAUNCH) begin
                send_start_q <= 1'b0;
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign sendStart = send_start_q;
    assign sendData  = send_data_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: behavioural SPI Master + slave (slave shifts 8'b10000011),
// a round-robin reference model, and a response scoreboard.
module tb_spi_txn_arbiter;
    import spi_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int ST = 64;
    localparam int XT = 1024;
    localparam int G  = 2;
    localparam int EW = 21;   // {kind[1:0], idx[2:0], rsp_byte[7:0], sent_byte[7:0]}
    localparam logic [W-1:0] SLAVE_BYTE = 8'b1000_0011;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   reqValid = '0;
    logic [N*W-1:0] reqData = '0;
    logic [N-1:0]   reqReady, rspValid;
    logic [W-1:0]   rspData, sendData;
    logic           rspError, busy, sendStart, SPI_CS;
    arb_state_t     dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [EW-1:0] exp_q[$];

    // reference-model state (driver side)
    int           last_served = N - 1;
    int           n_acc = 0;
    int           cur_kind = 0;   // 0 normal, 1 start timeout, 2 transfer timeout
    logic         hold = 1'b0;
    logic         rand_on = 1'b0;
    logic [W-1:0] req_byte [N];

    // monitor side
    int   n_rsp = 0;
    int   last_rsp_cyc = -1000;
    int   t_ss_rise = 0;
    int   t_ss_fall = 0;
    logic ss_prev = 1'b0;

    // Master / slave model and CS fault injection
    logic         force_hi = 1'b0;
    logic         force_lo = 1'b0;
    logic         stuck_lo_en = 1'b0;
    logic         stuck_latched = 1'b0;
    logic         m_cs, m_busy;
    int           m_cnt;
    logic [W-1:0] m_sh, s_sh, slave_mosi, recvData;

    spi_txn_arbiter #(
        .NUM_REQ(N), .DATA_W(W), .START_TIMEOUT(ST), .XFER_TIMEOUT(XT), .GAP_CYCLES(G)
    ) dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqData(reqData), .reqReady(reqReady),
        .rspValid(rspValid), .rspData(rspData), .rspError(rspError), .busy(busy),
        .sendStart(sendStart), .sendData(sendData), .recvData(recvData), .SPI_CS(SPI_CS),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- Master + slave model (Master reset is ~rst, active-low) ----------------
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cs <= 1'b1; m_busy <= 1'b0; m_cnt <= 0;
            m_sh <= '0; s_sh <= '0; recvData <= '0; slave_mosi <= '0;
        end else if (!m_busy) begin
            if (sendStart) begin
                m_busy <= 1'b1; m_cs <= 1'b0; m_cnt <= 0;
                m_sh <= sendData; s_sh <= SLAVE_BYTE;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt % 2 == 1) begin
                m_sh <= {m_sh[W-2:0], s_sh[W-1]};
                s_sh <= {s_sh[W-2:0], m_sh[W-1]};
            end
            if (m_cnt == 2 * W) begin
                m_cs <= 1'b1; m_busy <= 1'b0;
                recvData <= m_sh; slave_mosi <= s_sh;
            end
        end
    end

    always @(posedge clk) stuck_latched <= stuck_lo_en & (stuck_latched | ~m_cs);
    assign SPI_CS = force_hi ? 1'b1 : (force_lo || stuck_latched) ? 1'b0 : m_cs;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input int i, input logic [W-1:0] d);
        req_byte[i] = d;
        reqData[i*W +: W] = d;
        reqValid[i] = 1'b1;
    endtask

    // One clock: check any acceptance against the model at negedge, then update stimulus.
    task automatic step();
        logic [N-1:0] acc;
        int           pick;
        logic [W-1:0] rd;
        acc = '0;
        @(negedge clk);
        if (!rst && reqReady != '0) begin
            pick = model_pick(reqValid, last_served);
            check("accept_grant", reqReady, (pick >= 0) ? (N'(1) << pick) : '0);
            check("accept_spacing", ((n_rsp == n_acc) && (cyc - last_rsp_cyc > G)) ? 1 : 0, 1);
            if (pick >= 0) begin
                rd = (cur_kind == 0) ? SLAVE_BYTE : '0;
                exp_q.push_back({2'(cur_kind), 3'(pick), rd, req_byte[pick]});
                last_served = pick;
            end
            n_acc++;
            acc = reqReady;
        end
        @(posedge clk);
        #1;
        if (!hold) reqValid = reqValid & ~acc;
        if (rand_on) begin
            for (int i = 0; i < N; i++) begin
                if (!reqValid[i] && $urandom_range(0, 5) == 0) issue(i, W'($urandom));
                else if (reqValid[i] && !acc[i] && $urandom_range(0, 40) == 0) reqValid[i] = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 20000;
        hold = 1'b0;
        rand_on = 1'b0;
        while ((reqValid != '0 || exp_q.size() != 0 || busy) && budget > 0) begin
            step();
            budget--;
        end
        check({"drain_", tag}, (budget > 0) ? 1 : 0, 1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            if (sendStart && !ss_prev) t_ss_rise = cyc;
            if (!sendStart && ss_prev) t_ss_fall = cyc;
            if (rspValid != '0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rspValid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_target", rspValid, N'(1) << e[18:16]);
                    check("rsp_data", rspData, e[15:8]);
                    check("rsp_error", rspError, (e[20:19] != 2'd0) ? 1 : 0);
                    if (e[20:19] == 2'd0) begin
                        check("slave_mosi", slave_mosi, e[7:0]);
                        check("start_until_cs_fall", t_ss_fall - t_ss_rise, 2);
                    end else if (e[20:19] == 2'd1) begin
                        check("start_timeout_latency", cyc - t_ss_rise, ST);
                    end else begin
                        check("xfer_timeout_latency", cyc - t_ss_fall, XT);
                    end
                end
                last_rsp_cyc = cyc;
                n_rsp++;
            end
        end
        ss_prev = sendStart;
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int target, budget;
        for (int i = 0; i < N; i++) req_byte[i] = '0;

        // Reset: outputs must be zero even with every request raised.
        reqValid = '1;
        reqData  = {N{8'hA5}};
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {reqReady, rspValid, rspData, rspError, busy, sendStart, sendData}, 0);
        check("reset_state", dbg_state, S_IDLE);
        reqValid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1. single request
        issue(0, 8'hC2);
        drain("single");
        check("gap_after_single", cyc - last_rsp_cyc, G + 1);

        // 2. contention, all four held
        issue(0, 8'h11); issue(1, 8'h22); issue(2, 8'h33); issue(3, 8'h44);
        drain("contention");

        // 3. fairness, 0 and 2 held continuously
        hold = 1'b1;
        issue(0, 8'hAA); issue(2, 8'hBB);
        target = n_acc + 6;
        budget = 2000;
        while (n_acc < target && budget > 0) begin step(); budget--; end
        check("fairness_progress", (budget > 0) ? 1 : 0, 1);
        drain("fairness");

        // 4. start timeout: CS forced high
        force_hi = 1'b1; cur_kind = 1;
        issue(1, 8'h55);
        drain("start_timeout");
        force_hi = 1'b0; cur_kind = 0;
        idle(40);

        // 4b. CS already low when LAUNCH begins
        force_lo = 1'b1;
        idle(3);
        cur_kind = 1;
        issue(2, 8'h3C);
        drain("cs_stuck_low");
        force_lo = 1'b0; cur_kind = 0;
        idle(40);

        // 5. transfer timeout: CS held low after its falling edge
        stuck_lo_en = 1'b1; cur_kind = 2;
        issue(3, 8'h5A);
        drain("xfer_timeout");
        check("gap_after_xfer_timeout", cyc - last_rsp_cyc, G + 1);
        stuck_lo_en = 1'b0; cur_kind = 0;
        idle(40);

        // 6. reset mid-transfer
        issue(0, 8'h66);
        target = n_acc + 1;
        budget = 200;
        while (!(n_acc >= target && busy && !sendStart && SPI_CS == 1'b0) && budget > 0) begin
            step(); budget--;
        end
        check("reach_xfer", (budget > 0) ? 1 : 0, 1);
        idle(3);
        rst = 1'b1;
        #1;
        check("midxfer_reset_outputs", {reqReady, rspValid, rspData, rspError, busy, sendStart, sendData}, 0);
        exp_q.delete();
        last_served = N - 1;
        n_acc = n_rsp;
        reqValid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(0, 8'h71); issue(1, 8'h72);
        drain("after_reset");

        // randomized traffic
        rand_on = 1'b1;
        idle(2500);
        drain("random");

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
